// File: rtl/lcd_pkg.sv
// lcd_pkg: constants shared by the LCD character writer and the display
// decoder.
//   - HD44780 command bytes used by the writer
//   - top-level sequencer state encoding (ST_*)
//   - bus-cycle phase encoding (PH_*)
//   - ASCII character codes produced by the display decoder
//   - init_cmd(): the power-up command table, indexed 0..4
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME_ADDR = 8'h80;

  // Sequencer states
  localparam logic [2:0] ST_PWRUP = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_IDLE  = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_WRAP  = 3'd4;
  localparam logic [2:0] ST_CLEAR = 3'd5;

  // Bus-cycle phases
  localparam logic [2:0] PH_PWR   = 3'd0;
  localparam logic [2:0] PH_IDLE  = 3'd1;
  localparam logic [2:0] PH_SETUP = 3'd2;
  localparam logic [2:0] PH_PULSE = 3'd3;
  localparam logic [2:0] PH_WAIT  = 3'd4;

  // Character codes from the display decoder
  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_1   = 8'h31;
  localparam logic [7:0] CHAR_2   = 8'h32;
  localparam logic [7:0] CHAR_3   = 8'h33;
  localparam logic [7:0] CHAR_4   = 8'h34;
  localparam logic [7:0] CHAR_5   = 8'h35;
  localparam logic [7:0] CHAR_6   = 8'h36;
  localparam logic [7:0] CHAR_7   = 8'h37;
  localparam logic [7:0] CHAR_8   = 8'h38;
  localparam logic [7:0] CHAR_9   = 8'h39;
  localparam logic [7:0] CHAR_ERR = 8'h3A;

  // Power-up command table: function set twice, display on, entry mode, clear.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = CMD_FUNC_8BIT;
      3'd2:       init_cmd = CMD_DISP_ON;
      3'd3:       init_cmd = CMD_ENTRY;
      default:    init_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: timing engine for one HD44780 write.
// After reset it first counts out the power-up delay (phase PH_PWR). Each
// write then runs SETUP (EN low, RS/DATA driven) -> PULSE (EN high) ->
// WAIT (EN low, RS/DATA held). A single down-counter times every phase.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, rs, data     begin a write; only honoured when done or idle
//   long_wait           use CLR_WAIT_CYC instead of CMD_WAIT_CYC for WAIT
//   done                last cycle of power-up delay or of WAIT
//   lcd_rs/lcd_en/lcd_data  registered LCD pins
//   phase               current phase (debug)
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 1000000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic [2:0] phase
);

  localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
  localparam int MAX_B   = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
  localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  logic [CNT_W-1:0] cnt;
  logic             long_q;

  // done is combinational so the sequencer can chain the next write onto
  // the edge that ends this one, with no idle cycle in between.
  assign done = ((phase == PH_PWR) || (phase == PH_WAIT)) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_PWR;
      cnt      <= CNT_W'(PWRUP_CYC - 1);
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start && (done || (phase == PH_IDLE))) begin
      phase    <= PH_SETUP;
      cnt      <= CNT_W'(SETUP_CYC - 1);
      long_q   <= long_wait;
      lcd_rs   <= rs;
      lcd_data <= data;
    end else begin
      case (phase)
        PH_PWR: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           phase <= PH_IDLE;
        end
        PH_SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            lcd_en <= 1'b1;
            phase  <= PH_PULSE;
            cnt    <= CNT_W'(EN_CYC - 1);
          end
        end
        PH_PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            lcd_en <= 1'b0;
            phase  <= PH_WAIT;
            cnt    <= long_q ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
          end
        end
        PH_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           phase <= PH_IDLE;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: sequencer for an HD44780 8-bit LCD. Runs the power-up
// init, accepts characters, tracks the cursor column with wrap to the line
// start, and services clear requests.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   char_in, char_valid   character to write
//   char_ready            character accepted on an edge with char_valid high
//   clear_req             single-cycle display clear request
//   init_done             init sequence complete (held until reset)
//   lcd_rs/rw/en/data     LCD pins (rw is always 0)
//   dbg_state, dbg_bus_phase, dbg_col  debug visibility of FSMs and column
// Handshake: a character transfers on a rising clk edge where
// char_valid && char_ready; char_ready is high only in IDLE with no clear
// pending or requested, so a clear always wins over a same-cycle character.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC    = 1000000,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int COLS         = 16,
  localparam int COL_W       = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             clear_req,
  output logic             init_done,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  output logic [7:0]       lcd_data,
  output logic [2:0]       dbg_state,
  output logic [2:0]       dbg_bus_phase,
  output logic [COL_W-1:0] dbg_col
);

  logic [2:0]       state;
  logic [2:0]       init_idx;
  logic [COL_W-1:0] col;
  logic             clr_pend;
  logic             bus_done;
  logic             start;
  logic             start_rs;
  logic [7:0]       start_data;
  logic             start_long;
  logic             at_last_col;

  assign at_last_col   = (col == COL_W'(COLS - 1));
  assign char_ready    = (state == ST_IDLE) && !clr_pend && !clear_req;
  assign lcd_rw        = 1'b0;
  assign dbg_state     = state;
  assign dbg_col       = col;

  // Every write is launched on the edge the sequencer changes state, so the
  // write's SETUP phase starts the cycle after the deciding edge.
  always_comb begin
    start      = 1'b0;
    start_rs   = 1'b0;
    start_data = 8'h00;
    case (state)
      ST_PWRUP: begin
        if (bus_done) begin
          start      = 1'b1;
          start_data = init_cmd(3'd0);
        end
      end
      ST_INIT: begin
        if (bus_done && (init_idx != 3'd4)) begin
          start      = 1'b1;
          start_data = init_cmd(init_idx + 3'd1);
        end
      end
      ST_IDLE: begin
        if (clear_req || clr_pend) begin
          start      = 1'b1;
          start_data = CMD_CLEAR;
        end else if (char_valid) begin
          start      = 1'b1;
          start_rs   = 1'b1;
          start_data = char_in;
        end
      end
      ST_XFER: begin
        if (bus_done && at_last_col) begin
          start      = 1'b1;
          start_data = CMD_HOME_ADDR;
        end
      end
      default: ;
    endcase
    // Only the clear command needs the long post-EN wait.
    start_long = !start_rs && (start_data == CMD_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_PWRUP;
      init_idx  <= 3'd0;
      col       <= '0;
      clr_pend  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_PWRUP: begin
          clr_pend <= 1'b0;
          if (bus_done) begin
            init_idx <= 3'd0;
            state    <= ST_INIT;
          end
        end
        ST_INIT: begin
          clr_pend <= 1'b0;
          if (bus_done) begin
            if (init_idx == 3'd4) begin
              col       <= '0;
              init_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              init_idx <= init_idx + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (clear_req || clr_pend) state <= ST_CLEAR;
          else if (char_valid)       state <= ST_XFER;
        end
        ST_XFER: begin
          if (clear_req) clr_pend <= 1'b1;
          if (bus_done) begin
            if (at_last_col) begin
              state <= ST_WRAP;
            end else begin
              col   <= col + 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_WRAP: begin
          if (clear_req) clr_pend <= 1'b1;
          if (bus_done) begin
            col   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // A request arriving during the clear is satisfied by this clear.
          if (bus_done) begin
            col      <= '0;
            clr_pend <= 1'b0;
            state    <= ST_IDLE;
          end else if (clear_req) begin
            clr_pend <= 1'b1;
          end
        end
        default: state <= ST_PWRUP;
      endcase
    end
  end

  lcd_bus_cycle #(
    .PWRUP_CYC    (PWRUP_CYC),
    .SETUP_CYC    (SETUP_CYC),
    .EN_CYC       (EN_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_bus (
    .clk       (clk),
    .rst       (reset),
    .start     (start),
    .rs        (start_rs),
    .data      (start_data),
    .long_wait (start_long),
    .done      (bus_done),
    .lcd_rs    (lcd_rs),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .phase     (dbg_bus_phase)
  );

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer with short timing parameters.
module tb_lcd_char_writer;
  import lcd_pkg::*;

  localparam int PWRUP_CYC    = 10;
  localparam int SETUP_CYC    = 2;
  localparam int EN_CYC       = 3;
  localparam int CMD_WAIT_CYC = 5;
  localparam int CLR_WAIT_CYC = 20;
  localparam int COLS         = 4;
  localparam int COL_W        = $clog2(COLS);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [7:0]       char_in = 8'h00;
  logic             char_valid = 1'b0;
  logic             clear_req = 1'b0;
  logic             char_ready;
  logic             init_done;
  logic             lcd_rs;
  logic             lcd_rw;
  logic             lcd_en;
  logic [7:0]       lcd_data;
  logic [2:0]       dbg_state;
  logic [2:0]       dbg_bus_phase;
  logic [COL_W-1:0] dbg_col;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int last_fall_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_char_writer #(
    .PWRUP_CYC    (PWRUP_CYC),
    .SETUP_CYC    (SETUP_CYC),
    .EN_CYC       (EN_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC),
    .COLS         (COLS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .char_in       (char_in),
    .char_valid    (char_valid),
    .char_ready    (char_ready),
    .clear_req     (clear_req),
    .init_done     (init_done),
    .lcd_rs        (lcd_rs),
    .lcd_rw        (lcd_rw),
    .lcd_en        (lcd_en),
    .lcd_data      (lcd_data),
    .dbg_state     (dbg_state),
    .dbg_bus_phase (dbg_bus_phase),
    .dbg_col       (dbg_col)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Each entry is {rs, data} of one expected bus write, in bus order.
  logic [8:0] exp_q[$];

  task automatic push_init();
    exp_q.push_back({1'b0, CMD_FUNC_8BIT});
    exp_q.push_back({1'b0, CMD_FUNC_8BIT});
    exp_q.push_back({1'b0, CMD_DISP_ON});
    exp_q.push_back({1'b0, CMD_ENTRY});
    exp_q.push_back({1'b0, CMD_CLEAR});
  endtask

  logic       en_prev = 1'b0;
  int         en_len = 0;
  int         stable_cnt = 0;
  logic [8:0] last_bus = 9'h000;
  logic [8:0] held_bus = 9'h000;

  always @(negedge clk) begin : monitor
    logic [8:0] cur_bus;
    logic [8:0] exp_w;
    if (reset) begin
      en_prev    = 1'b0;
      en_len     = 0;
      stable_cnt = 0;
      last_bus   = 9'h000;
    end else begin
      cur_bus = {lcd_rs, lcd_data};
      if (lcd_en && !en_prev) begin
        check("setup_ge_2", 32'(stable_cnt >= SETUP_CYC), 32'd1);
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL unexpected_write: got rs=%0b data=0x%02h, expected no write",
                   lcd_rs, lcd_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_write", 32'(cur_bus), 32'(exp_w));
        end
        held_bus   = cur_bus;
        en_len     = 1;
        stable_cnt = 0;
      end else if (lcd_en) begin
        en_len++;
        check("hold_during_en", 32'(cur_bus), 32'(held_bus));
      end else begin
        if (en_prev) begin
          check("en_width", 32'(en_len), 32'(EN_CYC));
          last_fall_cyc = cyc;
        end
        if (cur_bus == last_bus) stable_cnt++;
        else                     stable_cnt = 1;
      end
      check("rw_zero", 32'(lcd_rw), 32'd0);
      en_prev  = lcd_en;
      last_bus = cur_bus;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name, output int rdy_cyc);
    int n = 0;
    while (!char_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: char_ready=0 after 500 cycles, expected 1", name);
    end
    rdy_cyc = cyc;
  endtask

  // Drives char_valid from a negedge until the accepting edge; returns just
  // after that edge.
  task automatic send_char(input logic [7:0] ch);
    int rc;
    @(negedge clk);
    char_in    = ch;
    char_valid = 1'b1;
    wait_ready("send", rc);
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!init_done) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: init_done=0 after 1000 cycles, expected 1", name);
    end else begin
      check({name, "_after_clr_wait"}, 32'(cyc - last_fall_cyc), 32'(CLR_WAIT_CYC));
      check({name, "_ready"}, 32'(char_ready), 32'd1);
      check({name, "_col"}, 32'(dbg_col), 32'd0);
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int rc;
    int en_first;
    int low_cnt;
    int bus_bad;
    int n;

    // Reset state
    reset = 1'b1;
    #1;
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);
    check("rst_ready", 32'(char_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_col", 32'(dbg_col), 32'd0);
    push_init();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Power-up delay: nothing visible yet
    repeat (5) @(negedge clk);
    check("pwrup_ready_low", 32'(char_ready), 32'd0);
    check("pwrup_en_low", 32'(lcd_en), 32'd0);
    wait_init("init1");

    // Single character: timing relative to the accepting edge T
    exp_q.push_back({1'b1, CHAR_1});
    send_char(CHAR_1);
    en_first = -1;
    low_cnt  = 0;
    bus_bad  = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (char_ready) break;
      low_cnt++;
      if (lcd_en && en_first < 0) en_first = k;
      if ({lcd_rs, lcd_data} != {1'b1, CHAR_1}) bus_bad++;
    end
    check("char_en_offset", 32'(en_first), 32'(SETUP_CYC));
    check("char_ready_low_cycles", 32'(low_cnt), 32'(SETUP_CYC + EN_CYC + CMD_WAIT_CYC));
    check("char_bus_held", 32'(bus_bad), 32'd0);
    check("char_col", 32'(dbg_col), 32'd1);

    // Clear to put the cursor back at column 0
    exp_q.push_back({1'b0, CMD_CLEAR});
    pulse_clear();
    wait_ready("clr0", rc);
    check("clr0_col", 32'(dbg_col), 32'd0);

    // Stream with wrap after the fourth character
    exp_q.push_back({1'b1, CHAR_1});
    send_char(CHAR_1);
    exp_q.push_back({1'b1, CHAR_2});
    send_char(CHAR_2);
    exp_q.push_back({1'b1, CHAR_ERR});
    send_char(CHAR_ERR);
    exp_q.push_back({1'b1, CHAR_0});
    send_char(CHAR_0);
    exp_q.push_back({1'b0, CMD_HOME_ADDR});
    wait_ready("wrap", rc);
    check("wrap_col", 32'(dbg_col), 32'd0);
    exp_q.push_back({1'b1, CHAR_5});
    send_char(CHAR_5);
    wait_ready("stream", rc);
    check("stream_col", 32'(dbg_col), 32'd1);

    // Same-cycle clear and character: clear first
    exp_q.push_back({1'b0, CMD_CLEAR});
    exp_q.push_back({1'b1, CHAR_9});
    char_in    = CHAR_9;
    char_valid = 1'b1;
    clear_req  = 1'b1;
    #1;
    check("clr_vs_char_ready", 32'(char_ready), 32'd0);
    @(posedge clk);
    #1 clear_req = 1'b0;
    @(negedge clk);
    wait_ready("clr_vs_char", rc);
    check("clr_vs_char_wait", 32'(rc - last_fall_cyc), 32'(CLR_WAIT_CYC));
    check("clr_vs_char_col", 32'(dbg_col), 32'd0);
    @(posedge clk);
    #1 char_valid = 1'b0;
    @(negedge clk);
    wait_ready("after_9", rc);
    check("after_9_col", 32'(dbg_col), 32'd1);

    // Clear request during a character transfer
    exp_q.push_back({1'b1, CHAR_3});
    send_char(CHAR_3);
    repeat (3) @(negedge clk);
    exp_q.push_back({1'b0, CMD_CLEAR});
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    @(negedge clk);
    check("mid_xfer_ready_low", 32'(char_ready), 32'd0);
    wait_ready("mid_xfer", rc);
    check("mid_xfer_clr_wait", 32'(rc - last_fall_cyc), 32'(CLR_WAIT_CYC));
    check("mid_xfer_col", 32'(dbg_col), 32'd0);

    // Reset while EN is high
    exp_q.push_back({1'b1, CHAR_4});
    send_char(CHAR_4);
    n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_en_high", 32'(lcd_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_en", 32'(lcd_en), 32'd0);
    check("async_rst_rs", 32'(lcd_rs), 32'd0);
    check("async_rst_data", 32'(lcd_data), 32'd0);
    check("async_rst_init_done", 32'(init_done), 32'd0);
    check("async_rst_ready", 32'(char_ready), 32'd0);
    push_init();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    wait_init("init2");

    // Writer works again after re-init
    exp_q.push_back({1'b1, CHAR_6});
    send_char(CHAR_6);
    @(negedge clk);
    wait_ready("final", rc);
    check("final_col", 32'(dbg_col), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
